// File: rtl/rx_ctrl_fsm.sv
// rx_ctrl_fsm -- receive control unit for the UART receiver.
// Sequences one frame: start-bit validation, N data bits (5..MAX_DATA_BITS),
// optional even/odd parity, then NUM_STOP_BITS stop bits. It counts timer
// strobes itself and drives the stop-bit checker, timer, shift register and
// receive buffer.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   start_bit_detected  start-edge pulse (honoured only in IDLE)
//   shift_strobe        bit-centre sample pulse from the timer
//   sample_bit          line value, valid with shift_strobe
//   data_bits           data length for the next frame (latched at start)
//   parity_mode         00 none, 01 even, 10 odd, 11 none (latched at start)
//   framing_error       stop-bit checker result, read in STOP_CHK
//   sbc_clear/sbc_enable, enable_timer, shift_enable, load_buffer  controls
//   parity_error, frame_error  sticky per-frame error flags
//   false_start         one-cycle pulse when the start bit is rejected
//   busy                high outside IDLE
module rx_ctrl_fsm #(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned NUM_STOP_BITS = 1,
  parameter int unsigned DBW           = $clog2(MAX_DATA_BITS + 1)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start_bit_detected,
  input  logic           shift_strobe,
  input  logic           sample_bit,
  input  logic [DBW-1:0] data_bits,
  input  logic [1:0]     parity_mode,
  input  logic           framing_error,
  output logic           sbc_clear,
  output logic           sbc_enable,
  output logic           enable_timer,
  output logic           shift_enable,
  output logic           load_buffer,
  output logic           parity_error,
  output logic           frame_error,
  output logic           false_start,
  output logic           busy
);

  typedef enum logic [2:0] {
    IDLE, START_CLR, START_CHK, DATA, PARITY, STOP, STOP_CHK, LOAD
  } state_t;

  localparam logic [DBW-1:0] MIN_LEN   = DBW'(5);
  localparam logic [DBW-1:0] MAX_LEN   = DBW'(MAX_DATA_BITS);
  localparam logic           LAST_STOP = 1'(NUM_STOP_BITS - 1);

  state_t         state_q, state_d;
  logic [DBW-1:0] len_q, len_d;
  logic [1:0]     pmode_q, pmode_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic           acc_q, acc_d;
  logic           par_err_q, par_err_d;
  logic           stop_err_q, stop_err_d;
  logic           stop_cnt_q, stop_cnt_d;
  logic           parity_error_q, parity_error_d;
  logic           frame_error_q, frame_error_d;
  logic           false_start_q, false_start_d;
  logic           par_en;

  assign par_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      pmode_q        <= '0;
      cnt_q          <= '0;
      acc_q          <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      stop_cnt_q     <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      false_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      pmode_q        <= pmode_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
      stop_cnt_q     <= stop_cnt_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      false_start_q  <= false_start_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    pmode_d        = pmode_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    par_err_d      = par_err_q;
    stop_err_d     = stop_err_q;
    stop_cnt_d     = stop_cnt_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    false_start_d  = 1'b0;
    shift_enable   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_bit_detected) begin
          if (data_bits < MIN_LEN)      len_d = MIN_LEN;
          else if (data_bits > MAX_LEN) len_d = MAX_LEN;
          else                          len_d = data_bits;
          pmode_d = parity_mode;
          state_d = START_CLR;
        end
      end
      START_CLR: begin
        parity_error_d = 1'b0;
        frame_error_d  = 1'b0;
        cnt_d          = '0;
        acc_d          = 1'b0;
        par_err_d      = 1'b0;
        stop_err_d     = 1'b0;
        stop_cnt_d     = 1'b0;
        state_d        = START_CHK;
      end
      START_CHK: begin
        if (shift_strobe) begin
          if (sample_bit) begin
            false_start_d = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (shift_strobe) begin
          shift_enable = 1'b1;
          acc_d        = acc_q ^ sample_bit;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (shift_strobe) begin
          // pmode_q[1] set means odd: expected bit is the inverted accumulator.
          par_err_d = sample_bit ^ acc_q ^ pmode_q[1];
          state_d   = STOP;
        end
      end
      STOP: begin
        if (shift_strobe) begin
          if (!sample_bit) stop_err_d = 1'b1;
          if (stop_cnt_q == LAST_STOP) state_d = STOP_CHK;
          else                         stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      STOP_CHK: begin
        if (framing_error || stop_err_q) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (par_err_q) begin
          parity_error_d = 1'b1;
          state_d        = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sbc_clear    = (state_q == START_CLR);
  assign sbc_enable   = (state_q == STOP_CHK);
  assign load_buffer  = (state_q == LOAD);
  assign enable_timer = (state_q == START_CLR) || (state_q == START_CHK) ||
                        (state_q == DATA) || (state_q == PARITY) ||
                        (state_q == STOP);
  assign busy         = (state_q != IDLE);
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign false_start  = false_start_q;

endmodule
